// File: rtl/eq_reg_bank_pkg.sv
// Shared definitions for the equaliser gain register bank: register bit
// positions, the CONFIG address and the commit state encoding.
package eq_reg_bank_pkg;

  // Commit sequencer states
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } eq_state_e;

  // CONFIG register location and bit positions
  localparam int CONFIG_ADDR    = 0;
  localparam int CFG_COMMIT_BIT = 0;
  localparam int CFG_AUTO_BIT   = 1;
  localparam int CFG_LOCK_BIT   = 7;

  // STATUS register bit positions
  localparam int STS_ERR_BIT    = 0;
  localparam int STS_BUSY_BIT   = 1;
  localparam int STS_LOCK_BIT   = 2;

  // Width of a band index (up to 16 bands)
  localparam int BAND_IDX_W     = 4;

endpackage

// File: rtl/eq_reg_bank_if.sv
// Byte-wide register access bus for the equaliser gain bank.
interface eq_reg_bank_if #(
  parameter int ADDR_WIDTH = 6
) ();

  logic                  we;
  logic                  re;
  logic [ADDR_WIDTH-1:0] addr;
  logic [7:0]            data_in;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic                  err;

  modport master (
    output we, re, addr, data_in,
    input  rd_data, rd_valid, err
  );

  modport slave (
    input  we, re, addr, data_in,
    output rd_data, rd_valid, err
  );

endinterface

// File: rtl/eq_gain_slot.sv
// One equaliser band: byte-writable shadow gain plus the active gain that
// is loaded from the shadow when copy_en is high.
module eq_gain_slot #(
  parameter int GAIN_WIDTH = 24,
  parameter int ADDR_WIDTH = 6,
  parameter int BASE       = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            data_in,
  input  logic                  copy_en,
  output logic [GAIN_WIDTH-1:0] shadow,
  output logic [GAIN_WIDTH-1:0] active,
  output logic                  msb_hit
);

  localparam int BPG = GAIN_WIDTH / 8;

  logic [BPG-1:0]        byte_sel_s;
  logic [GAIN_WIDTH-1:0] shadow_r;
  logic [GAIN_WIDTH-1:0] active_r;

  // Decode which byte of this band (if any) the current write targets
  always_comb begin
    byte_sel_s = '0;
    for (int j = 0; j < BPG; j++) begin
      byte_sel_s[j] = wr_en && (addr == ADDR_WIDTH'(BASE + j));
    end
  end

  // Shadow gain: updated byte by byte from the bus
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_r <= '0;
    end else begin
      for (int j = 0; j < BPG; j++) begin
        if (byte_sel_s[j]) begin
          shadow_r[8*j +: 8] <= data_in;
        end
      end
    end
  end

  // Active gain: takes the shadow value as it stood before this edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_r <= '0;
    end else if (copy_en) begin
      active_r <= shadow_r;
    end
  end

  assign shadow  = shadow_r;
  assign active  = active_r;
  assign msb_hit = byte_sel_s[BPG-1];

endmodule

// File: rtl/eq_reg_bank.sv
// Equaliser gain register bank: byte-addressed CONFIG/STATUS/shadow gains,
// with explicit or per-band automatic commit of shadow gains to the active set.
module eq_reg_bank
  import eq_reg_bank_pkg::*;
#(
  parameter int NUM_BANDS  = 10,
  parameter int GAIN_WIDTH = 24,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  eq_reg_bank_if.slave                    bus,
  output logic [7:0]                      configuration,
  output logic [NUM_BANDS*GAIN_WIDTH-1:0] gains,
  output logic                            gains_update
);

  localparam int BPG       = GAIN_WIDTH / 8;
  localparam int NUM_BYTES = NUM_BANDS * BPG;
  localparam logic [ADDR_WIDTH-1:0] CFG_ADDR  = ADDR_WIDTH'(CONFIG_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STS_ADDR  = ADDR_WIDTH'(NUM_BYTES + 1);
  localparam logic [ADDR_WIDTH-1:0] GAIN_LO   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] GAIN_HI   = ADDR_WIDTH'(NUM_BYTES);

  eq_state_e state_r, state_next_s;

  logic [7:0]            config_r;
  logic                  err_sticky_r;
  logic                  err_r;
  logic [7:0]            rd_data_r;
  logic                  rd_valid_r;
  logic                  gains_update_r;
  logic                  pend_full_r;
  logic [BAND_IDX_W-1:0] pend_band_r;

  logic is_cfg_s, is_sts_s, is_gain_s, mapped_s;
  logic gain_wr_s, cfg_wr_s, ill_wr_s, unmapped_rd_s;
  logic req_full_s, req_auto_s;
  logic [BAND_IDX_W-1:0] band_hit_s;
  logic [NUM_BANDS-1:0]  msb_hit_s;
  logic [NUM_BANDS-1:0]  copy_en_s;
  logic [7:0]            status_s;
  logic [7:0]            rd_val_s;
  logic [GAIN_WIDTH-1:0] shadow_s [NUM_BANDS];
  logic [GAIN_WIDTH-1:0] active_s [NUM_BANDS];

  // Address decode, access legality and commit request detection
  always_comb begin
    is_cfg_s      = (bus.addr == CFG_ADDR);
    is_sts_s      = (bus.addr == STS_ADDR);
    is_gain_s     = (bus.addr >= GAIN_LO) && (bus.addr <= GAIN_HI);
    mapped_s      = is_cfg_s || is_sts_s || is_gain_s;
    gain_wr_s     = bus.we && is_gain_s && !config_r[CFG_LOCK_BIT];
    cfg_wr_s      = bus.we && is_cfg_s;
    ill_wr_s      = bus.we && ((is_gain_s && config_r[CFG_LOCK_BIT]) || is_sts_s || !mapped_s);
    unmapped_rd_s = bus.re && !mapped_s;
    req_full_s    = cfg_wr_s && bus.data_in[CFG_COMMIT_BIT];
    req_auto_s    = config_r[CFG_AUTO_BIT] && (|msb_hit_s) && !req_full_s;
  end

  // Band whose MSB byte is being written (at most one per cycle)
  always_comb begin
    band_hit_s = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      if (msb_hit_s[k]) begin
        band_hit_s = BAND_IDX_W'(k);
      end else begin
        band_hit_s = band_hit_s;
      end
    end
  end

  // STATUS view; an illegal write in the same cycle is already reflected
  always_comb begin
    status_s               = 8'h00;
    status_s[STS_ERR_BIT]  = err_sticky_r || ill_wr_s;
    status_s[STS_BUSY_BIT] = (state_r == ST_COMMIT);
    status_s[STS_LOCK_BIT] = config_r[CFG_LOCK_BIT];
  end

  // Read data mux; a simultaneous legal write is returned in place of the old value
  always_comb begin
    rd_val_s = 8'h00;
    if (is_cfg_s) begin
      rd_val_s = cfg_wr_s ? {bus.data_in[7:1], 1'b0} : config_r;
    end else if (is_sts_s) begin
      rd_val_s = status_s;
    end else if (gain_wr_s) begin
      rd_val_s = bus.data_in;
    end else if (is_gain_s) begin
      for (int k = 0; k < NUM_BANDS; k++) begin
        for (int j = 0; j < BPG; j++) begin
          if (bus.addr == ADDR_WIDTH'(1 + k*BPG + j)) begin
            rd_val_s = shadow_s[k][8*j +: 8];
          end else begin
            rd_val_s = rd_val_s;
          end
        end
      end
    end else begin
      rd_val_s = 8'h00;
    end
  end

  // CONFIG storage, error reporting and read response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      config_r     <= 8'h00;
      err_sticky_r <= 1'b0;
      err_r        <= 1'b0;
      rd_data_r    <= 8'h00;
      rd_valid_r   <= 1'b0;
    end else begin
      if (cfg_wr_s) begin
        config_r <= {bus.data_in[7:1], 1'b0};
      end
      if (ill_wr_s) begin
        err_sticky_r <= 1'b1;
      end else if (bus.re && is_sts_s) begin
        err_sticky_r <= 1'b0;
      end
      err_r      <= ill_wr_s || unmapped_rd_s;
      rd_valid_r <= bus.re;
      if (bus.re) begin
        rd_data_r <= rd_val_s;
      end
    end
  end

  // Commit sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Commit sequencer next state: any request (including one seen while
  // committing) leads to a COMMIT cycle next
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   state_next_s = (req_full_s || req_auto_s) ? ST_COMMIT : ST_IDLE;
      ST_COMMIT: state_next_s = (req_full_s || req_auto_s) ? ST_COMMIT : ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // Latch what the upcoming COMMIT cycle copies; a full commit wins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_full_r <= 1'b0;
      pend_band_r <= '0;
    end else if (req_full_s) begin
      pend_full_r <= 1'b1;
      pend_band_r <= '0;
    end else if (req_auto_s) begin
      pend_full_r <= 1'b0;
      pend_band_r <= band_hit_s;
    end
  end

  // Update pulse coincides with the active gains changing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gains_update_r <= 1'b0;
    end else begin
      gains_update_r <= (state_r == ST_COMMIT);
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_band
    assign copy_en_s[k] = (state_r == ST_COMMIT) &&
                          (pend_full_r || (pend_band_r == BAND_IDX_W'(k)));

    eq_gain_slot #(
      .GAIN_WIDTH (GAIN_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BASE       (1 + k*BPG)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (gain_wr_s),
      .addr    (bus.addr),
      .data_in (bus.data_in),
      .copy_en (copy_en_s[k]),
      .shadow  (shadow_s[k]),
      .active  (active_s[k]),
      .msb_hit (msb_hit_s[k])
    );

    assign gains[k*GAIN_WIDTH +: GAIN_WIDTH] = active_s[k];
  end

  assign configuration = config_r;
  assign gains_update  = gains_update_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.rd_valid  = rd_valid_r;
  assign bus.err       = err_r;

endmodule

// File: doc/eq_reg_bank.md
EQ_REG_BANK -- requirements
Module: eq_reg_bank

Interface
REQ-001 SHALL have parameter NUM_BANDS, default 10, number of equaliser gain channels (1..16).
REQ-002 SHALL have parameter GAIN_WIDTH, default 24, gain width in bits; multiple of 8, 8..32; BPG = GAIN_WIDTH/8 is the derived bytes per gain.
REQ-003 SHALL have parameter ADDR_WIDTH, default 6, byte address width; must satisfy 2^ADDR_WIDTH > NUM_BANDS*BPG+1.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port we, input, 1, write strobe.
REQ-007 SHALL have port re, input, 1, read strobe.
REQ-008 SHALL have port addr, input, ADDR_WIDTH, byte address.
REQ-009 SHALL have port data_in, input, 8, write data.
REQ-010 SHALL have port rd_data, output, 8, read data.
REQ-011 SHALL have port rd_valid, output, 1, rd_data is valid.
REQ-012 SHALL have port configuration, output, 8, CONFIG register.
REQ-013 SHALL have port gains, output, NUM_BANDS*GAIN_WIDTH, active gains; band k occupies bits [k*GAIN_WIDTH +: GAIN_WIDTH], k=0..NUM_BANDS-1.
REQ-014 SHALL have port gains_update, output, 1, one-cycle pulse when any active gain changes.
REQ-015 SHALL have port err, output, 1, one-cycle pulse on an illegal access.

Function
REQ-016 SHALL use this address map: 0 = CONFIG (R/W); 1..NUM_BANDS*BPG = shadow gain bytes, band k byte j at 1+k*BPG+j, LSB first; S = NUM_BANDS*BPG+1 = STATUS (read-only); all others unmapped.
REQ-017 SHALL define the CONFIG bits: bit0 COMMIT (self-clearing, always reads 0), bit1 AUTO (auto-commit enable), bit7 LOCK (gain writes rejected); bits 6..2 are plain storage.
REQ-018 SHALL route gain writes to shadow registers only; the gains output changes only on a commit.
REQ-019 SHALL, when CONFIG is written with bit0=1, enter state COMMIT on the next cycle, copy all shadow registers to active, assert gains_update in that cycle, then return to IDLE.
REQ-020 SHALL, with AUTO=1, treat a write to the MSB byte (j=BPG-1) of band k as a request to copy band k alone, one cycle later, with gains_update asserted.
REQ-021 SHALL make each commit copy the shadow values as registered at the end of the request cycle; a gain write landing in the copy cycle is not included and needs a later commit.
REQ-022 SHALL, when a full-commit request and an auto-commit request fall in the same cycle, perform the full commit only.
REQ-023 SHALL accept a new commit request during the COMMIT cycle and execute it in the following cycle; requests are never dropped.
REQ-024 SHALL, on a read with re=1, drive rd_data with the addressed content on the next cycle and assert rd_valid for one cycle; rd_data holds its value otherwise; a shadow byte reads its shadow value.
REQ-025 SHALL define STATUS as: bit0 ERR sticky, bit1 COMMIT busy, bit2 LOCK mirror, bits 7..3 zero; a read of STATUS clears ERR after returning it.
REQ-026 SHALL treat these as illegal accesses: a write to an unmapped address, a write to STATUS, or a gain write while LOCK=1.
REQ-027 SHALL handle an illegal access by discarding it, pulsing err the next cycle, and setting ERR; a read of an unmapped address returns 0x00 with rd_valid and err.
REQ-028 SHALL, when we and re are both high, complete the write first and return the newly written data on the read.

Reset
REQ-029 SHALL, on rst low, clear all shadow and active gains, CONFIG, STATUS, rd_data, rd_valid, gains_update, err and pending requests to 0, with state IDLE, immediately and without clk.
REQ-030 SHALL abort any in-flight commit on reset; no gains_update is issued after reset release until a new request.

Structure
REQ-031 SHALL place the CONFIG and STATUS bit indices, the CONFIG address (0) and the state encoding (IDLE, COMMIT) in the shared eq package.
REQ-032 SHALL implement one sub-module, eq_gain_slot (one band: shadow + active register, copy enable), instantiated NUM_BANDS times by a generate loop.

Verification
REQ-033 SHALL verify: write band0 bytes 0x11,0x22,0x33 with AUTO=0 -> gains[23:0] stays 0; write CONFIG=0x01 -> one cycle later gains[23:0]=0x332211 with one gains_update pulse.
REQ-034 SHALL verify: with AUTO=1, write band9 addr 28,29,30 = 0xAA,0xBB,0xCC -> after the addr-30 write, band9=0xCCBBAA next cycle; other bands unchanged.
REQ-035 SHALL verify: CONFIG=0x80 then write addr 5 = 0x7F -> err pulse, STATUS reads 0x05, a second STATUS read returns 0x04, shadow addr 5 reads 0x00.
REQ-036 SHALL verify: write addr 1 = 0x55 during the COMMIT cycle of a prior commit -> gains excludes 0x55 until the next commit.
REQ-037 SHALL verify: rst low while the COMMIT state is pending -> all outputs 0 at once, no gains_update after release.
REQ-038 SHALL verify: read addr 40 (unmapped, default parameters) -> rd_data=0x00 with rd_valid=1 and err=1 one cycle later.
